// File: rtl/nios2_dbg_seq_pkg.sv
// Shared types and constants for the Nios II debug command sequencer.
package nios2_dbg_seq_pkg;
   localparam int JDO_W = 38;
   localparam int RSP_W = 32;

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_e;

   localparam logic [1:0] IR_OCIMEM = 2'b00;
   localparam logic [1:0] IR_TRACE  = 2'b01;
   localparam logic [1:0] IR_BREAK  = 2'b10;
   localparam logic [1:0] IR_RSVD   = 2'b11;

   // break sub-codes carried in jdo[37:36]
   localparam logic [1:0] BRK_A    = 2'b00;
   localparam logic [1:0] BRK_B    = 2'b01;
   localparam logic [1:0] BRK_C    = 2'b10;
   localparam logic [1:0] BRK_NONE = 2'b11;

   typedef struct packed {
      logic [1:0]       ir;
      logic [JDO_W-1:0] data;
   } dbg_req_t;
endpackage

// File: rtl/nios2_dbg_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last granted id.
module nios2_dbg_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd_en,
   input  logic       upd_id,
   output logic [1:0] gnt,
   output logic       gnt_id
);
   logic last;

   // pointer starts at 1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last <= 1'b1;
      else if (upd_en) last <= upd_id;
   end

   always_comb begin
      gnt_id = req[1];
      if (req == 2'b11) gnt_id = ~last;
      gnt = req & (gnt_id ? 2'b10 : 2'b01);
   end
endmodule

// File: rtl/nios2_debug_cmd_sequencer.sv
// Arbitrates two debug requesters onto the sysclk-side action interface,
// strobes one action per command and returns a response to the winner.
module nios2_debug_cmd_sequencer
   import nios2_dbg_seq_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [1:0]       req0_ir,
   input  logic [JDO_W-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_ir,
   input  logic [JDO_W-1:0] req1_data,
   output logic             req1_ready,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [RSP_W-1:0] rsp_data,
   output logic             rsp_error,
   output logic [JDO_W-1:0] jdo,
   output logic             take_action_ocimem_a,
   output logic             take_action_ocimem_b,
   output logic             take_action_break_a,
   output logic             take_action_break_b,
   output logic             take_action_break_c,
   output logic             take_action_tracectrl,
   input  logic             monitor_ready,
   input  logic             monitor_error,
   input  logic [RSP_W-1:0] MonDReg,
   input  logic [RSP_W-1:0] break_readreg
);
   state_e           state_q, state_d;
   logic [1:0]       ir_q;
   logic             id_q;
   logic [7:0]       cnt_q;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             idle, accept, rsp_take, timeout;
   logic             ld_rsp, err_d;
   logic [RSP_W-1:0] rsp_d;
   dbg_req_t         sel_req;

   assign idle     = (state_q == S_IDLE);
   assign rsp_take = (state_q == S_RESP) && (id_q ? rsp1_ready : rsp0_ready);
   assign timeout  = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);

   nios2_dbg_rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({req1_valid, req0_valid}),
      .upd_en (rsp_take),
      .upd_id (id_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = idle && gnt[0] && !reset;
   assign req1_ready = idle && gnt[1] && !reset;
   assign accept     = req0_ready || req1_ready;
   assign rsp0_valid = (state_q == S_RESP) && !id_q;
   assign rsp1_valid = (state_q == S_RESP) && id_q;
   assign sel_req    = gnt_id ? dbg_req_t'{req1_ir, req1_data} : dbg_req_t'{req0_ir, req0_data};

   always_comb begin
      state_d               = state_q;
      ld_rsp                = 1'b0;
      rsp_d                 = '0;
      err_d                 = 1'b0;
      take_action_ocimem_a  = 1'b0;
      take_action_ocimem_b  = 1'b0;
      take_action_break_a   = 1'b0;
      take_action_break_b   = 1'b0;
      take_action_break_c   = 1'b0;
      take_action_tracectrl = 1'b0;
      case (state_q)
         S_IDLE: if (accept) state_d = S_STROBE;
         S_STROBE: begin
            ld_rsp  = 1'b1;
            state_d = S_RESP;
            case (ir_q)
               IR_OCIMEM: begin
                  ld_rsp  = 1'b0;
                  state_d = S_WAIT;
                  if (jdo[37]) take_action_ocimem_a = 1'b1;
                  else         take_action_ocimem_b = 1'b1;
               end
               IR_TRACE: take_action_tracectrl = 1'b1;
               IR_BREAK: begin
                  rsp_d = break_readreg;
                  case (jdo[37:36])
                     BRK_A:    take_action_break_a = 1'b1;
                     BRK_B:    take_action_break_b = 1'b1;
                     BRK_C:    take_action_break_c = 1'b1;
                     BRK_NONE: ;
                     default:  ;
                  endcase
               end
               default: err_d = 1'b1;
            endcase
         end
         S_WAIT: begin
            // a completion on the timeout cycle still returns monitor data
            if (monitor_ready) begin
               ld_rsp  = 1'b1;
               state_d = S_RESP;
               rsp_d   = MonDReg;
               err_d   = monitor_error;
            end else if (monitor_error || timeout) begin
               ld_rsp  = 1'b1;
               state_d = S_RESP;
               err_d   = 1'b1;
            end
         end
         S_RESP: if (rsp_take) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         id_q      <= 1'b0;
         jdo       <= '0;
         cnt_q     <= '0;
         rsp_data  <= '0;
         rsp_error <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ir_q <= sel_req.ir;
            jdo  <= sel_req.data;
            id_q <= gnt_id;
         end
         if (state_q == S_WAIT) cnt_q <= cnt_q + 8'd1;
         else                   cnt_q <= '0;
         if (ld_rsp) begin
            rsp_data  <= rsp_d;
            rsp_error <= err_d;
         end
      end
   end
endmodule
